// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared dump FSM states and default parameters for the debug register file
package regfile_pkg;

  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_REG_COUNT   = 32;
  localparam int DEF_NUM_RD      = 3;
  localparam int DEF_ZERO_REG_EN = 1;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_LOAD = 2'd1,
    DUMP_SEND = 2'd2
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// rtl/regfile_dump_fsm.sv - walks every register index and streams one beat per register
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_COUNT  = DEF_REG_COUNT,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] load_idx,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last,
  output logic                  dump_active
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

  dump_state_t           state;
  dump_state_t           state_n;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] data_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DUMP_IDLE;
      idx       <= '0;
      dump_addr <= '0;
      dump_data <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      dump_addr <= addr_n;
      dump_data <= data_n;
    end
  end

  // Beat contents are captured only in LOAD, so they stay frozen through any SEND stall.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    addr_n      = dump_addr;
    data_n      = dump_data;
    dump_valid  = 1'b0;
    dump_last   = 1'b0;
    dump_active = (state != DUMP_IDLE);
    case (state)
      DUMP_IDLE: begin
        if (dump_start) begin
          state_n = DUMP_LOAD;
          idx_n   = '0;
        end
      end
      DUMP_LOAD: begin
        addr_n  = idx;
        data_n  = load_data;
        state_n = DUMP_SEND;
      end
      DUMP_SEND: begin
        dump_valid = 1'b1;
        dump_last  = (idx == LAST_IDX);
        if (dump_ready) begin
          if (idx == LAST_IDX) begin
            state_n = DUMP_IDLE;
            idx_n   = '0;
          end else begin
            state_n = DUMP_LOAD;
            idx_n   = idx + 1'b1;
          end
        end
      end
      default: state_n = DUMP_IDLE;
    endcase
  end

  assign load_idx = idx;

endmodule

// File: rtl/regfile_dbg.sv
// rtl/regfile_dbg.sv - multi-port register file with write bypass, busy scoreboard and debug dump
module regfile_dbg
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int REG_COUNT     = DEF_REG_COUNT,
  parameter int ADDR_WIDTH    = $clog2(REG_COUNT),
  parameter int NUM_RD        = DEF_NUM_RD,
  parameter int ZERO_REG_EN   = DEF_ZERO_REG_EN,
  parameter int ZERO_REG_ADDR = REG_COUNT - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         wr0_en,
  input  logic [ADDR_WIDTH-1:0]        wr0_addr,
  input  logic [DATA_WIDTH-1:0]        wr0_data,
  input  logic                         wr1_en,
  input  logic [ADDR_WIDTH-1:0]        wr1_addr,
  input  logic [DATA_WIDTH-1:0]        wr1_data,
  input  logic                         busy_set_en,
  input  logic [ADDR_WIDTH-1:0]        busy_set_addr,
  output logic [REG_COUNT-1:0]         busy_q,
  input  logic                         dump_start,
  output logic                         dump_valid,
  input  logic                         dump_ready,
  output logic [ADDR_WIDTH-1:0]        dump_addr,
  output logic [DATA_WIDTH-1:0]        dump_data,
  output logic                         dump_last,
  output logic                         dump_active
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG_ADDR);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  wr0_ok;
  logic                  wr1_ok;
  logic [ADDR_WIDTH-1:0] dump_idx;
  logic [DATA_WIDTH-1:0] dump_load_data;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG_EN != 0) && (a == ZERO_ADDR);
  endfunction

  assign wr0_ok = wr0_en && !is_zero(wr0_addr);
  assign wr1_ok = wr1_en && !is_zero(wr1_addr);

  // wr1 is assigned last so it wins an address collision with wr0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] val;

    assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      val = regs[addr];
      if (is_zero(addr)) begin
        val = '0;
      end else if (wr1_en && (wr1_addr == addr)) begin
        val = wr1_data;
      end else if (wr0_en && (wr0_addr == addr)) begin
        val = wr0_data;
      end
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = val;
  end

  // A new reservation outranks a writeback retiring the previous one on the same register.
  always_ff @(posedge clk) begin
    for (int a = 0; a < REG_COUNT; a++) begin
      if (rst) begin
        busy_q[a] <= 1'b0;
      end else if (busy_set_en && (busy_set_addr == ADDR_WIDTH'(a)) && !is_zero(busy_set_addr)) begin
        busy_q[a] <= 1'b1;
      end else if ((wr0_en && (wr0_addr == ADDR_WIDTH'(a))) ||
                   (wr1_en && (wr1_addr == ADDR_WIDTH'(a)))) begin
        busy_q[a] <= 1'b0;
      end
    end
  end

  assign dump_load_data = is_zero(dump_idx) ? '0 : regs[dump_idx];

  regfile_dump_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dump (
    .clk         (clk),
    .rst         (rst),
    .dump_start  (dump_start),
    .dump_ready  (dump_ready),
    .load_idx    (dump_idx),
    .load_data   (dump_load_data),
    .dump_valid  (dump_valid),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .dump_last   (dump_last),
    .dump_active (dump_active)
  );

endmodule
